// File: rtl/folded_neuron.sv
// Time-multiplexed neuron: P MAC lanes over N/P cycles, then saturate,
// truncate and apply a run-time selected activation.
module folded_neuron #(
  parameter int N  = 4,
  parameter int P  = 2,
  parameter int QM = 3,
  parameter int QN = 5,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [QM+QN-1:0]     in [N],
  input  logic signed [WM+WN-1:0]     weights [N],
  input  logic signed [QM+QN-1:0]     bias,
  input  logic [1:0]                  act_sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [QM+QN-1:0]     out,
  output logic                        sat
);

  localparam int DW = QM + QN;
  localparam int WW = WM + WN;
  localparam int K  = N / P;
  localparam int PW = DW + WW;
  localparam int AW = PW + $clog2(N) + 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam int HI = DW + WN - 1;

  typedef logic signed [AW-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, ACC, FIN, OUT} state_e;

  state_e               state_q, state_d;
  logic signed [DW-1:0] in_q [N];
  logic signed [DW-1:0] in_d [N];
  logic signed [WW-1:0] w_q [N];
  logic signed [WW-1:0] w_d [N];
  logic [1:0]           act_q, act_d;
  acc_t                 acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [DW-1:0] out_q, out_d;
  logic                 sat_q, sat_d;

  acc_t                 lane_sum;
  logic [AW-1:HI]       hi_bits;
  logic signed [DW-1:0] pre;
  logic signed [DW-1:0] act_out;
  logic                 sat_c;

  always_comb begin
    lane_sum = '0;
    for (int g = 0; g < K; g++) begin
      if (cnt_q == CW'(g)) begin
        for (int j = 0; j < P; j++) begin
          lane_sum = lane_sum
            + acc_t'(in_q[g*P+j]) * acc_t'(w_q[g*P+j]);
        end
      end
    end
  end

  // Clip when the bits above the output MSB disagree with the sign.
  always_comb begin
    hi_bits = acc_q[AW-1:HI];
    pre     = acc_q[HI:WN];
    sat_c   = 1'b0;
    if (!(&hi_bits) && |hi_bits) begin
      sat_c = 1'b1;
      pre   = acc_q[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                          : {1'b0, {(DW-1){1'b1}}};
    end
  end

  always_comb begin
    act_out = pre;
    case (act_q)
      2'b00:   act_out = pre;
      2'b10:   act_out = pre[DW-1] ? (pre >>> 3) : pre;
      default: act_out = pre[DW-1] ? '0 : pre;
    endcase
  end

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    w_d     = w_q;
    act_d   = act_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_d    = in;
          w_d     = weights;
          act_d   = act_sel;
          acc_d   = acc_t'(bias) <<< WN;
          cnt_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_d = acc_q + lane_sum;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(K - 1)) state_d = FIN;
      end
      FIN: begin
        out_d   = act_out;
        sat_d   = sat_c;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      act_q   <= 2'b00;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      sat_q   <= sat_d;
    end
  end

  always_ff @(posedge clk) begin
    in_q <= in_d;
    w_q  <= w_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign out       = out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_folded_neuron.sv
// Directed bench for folded_neuron; P=2 main instance plus P=1
// and P=4 instances for the latency checks.
module tb_folded_neuron;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              out_ready;
  logic signed [7:0] in_v [4];
  logic signed [15:0] w_v [4];
  logic signed [7:0] bias_v;
  logic [1:0]        act_v;

  logic              rdy2, vld2, sat2;
  logic signed [7:0] out2;
  logic              rdy1, vld1, sat1;
  logic signed [7:0] out1;
  logic              rdy4, vld4, sat4;
  logic signed [7:0] out4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  folded_neuron #(.N(4), .P(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .in(in_v), .weights(w_v), .bias(bias_v), .act_sel(act_v),
    .out_valid(vld2), .out_ready(out_ready), .out(out2), .sat(sat2)
  );

  folded_neuron #(.N(4), .P(1)) dut_p1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in(in_v), .weights(w_v), .bias(bias_v), .act_sel(act_v),
    .out_valid(vld1), .out_ready(out_ready), .out(out1), .sat(sat1)
  );

  folded_neuron #(.N(4), .P(4)) dut_p4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in(in_v), .weights(w_v), .bias(bias_v), .act_sel(act_v),
    .out_valid(vld4), .out_ready(out_ready), .out(out4), .sat(sat4)
  );

  task automatic set_all(input int a, input int w, input int b,
                         input logic [1:0] act);
    for (int i = 0; i < 4; i++) begin
      in_v[i] = 8'(a);
      w_v[i]  = 16'(w);
    end
    bias_v = 8'(b);
    act_v  = act;
  endtask

  task automatic set_lane0(input int a, input int w, input logic [1:0] act);
    for (int i = 0; i < 4; i++) begin
      in_v[i] = '0;
      w_v[i]  = '0;
    end
    in_v[0] = 8'(a);
    w_v[0]  = 16'(w);
    bias_v  = '0;
    act_v   = act;
  endtask

  // Present one operand set and wait (bounded) for the main result.
  task automatic issue(output int lat);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!vld2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", rdy2); end
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", vld2); end
    total++; if (out2 !== 0) begin bad++; $display("FAIL reset_out got %0d want 0", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL reset_sat got %b want 0", sat2); end
  endtask

  task automatic test_basic();
    int lat;
    set_all(32, 512, 16, 2'b01);
    issue(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL basic_latency got %0d want 3", lat); end
    total++; if (out2 !== 80) begin bad++; $display("FAIL basic_out got %0d want 80", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL basic_sat got %b want 0", sat2); end
    drain();
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL basic_drain got %b want 0", vld2); end
  endtask

  task automatic test_negative();
    int lat;
    set_all(32, -1024, 0, 2'b00);
    issue(lat);
    total++; if (out2 !== -128) begin bad++; $display("FAIL neg_linear got %0d want -128", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL neg_linear_sat got %b want 0", sat2); end
    drain();
    act_v = 2'b10;
    issue(lat);
    total++; if (out2 !== -16) begin bad++; $display("FAIL neg_leaky got %0d want -16", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL neg_leaky_sat got %b want 0", sat2); end
    drain();
    act_v = 2'b01;
    issue(lat);
    total++; if (out2 !== 0) begin bad++; $display("FAIL neg_relu got %0d want 0", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL neg_relu_sat got %b want 0", sat2); end
    drain();
  endtask

  task automatic test_saturation();
    int lat;
    set_all(96, 3072, 0, 2'b01);
    issue(lat);
    total++; if (out2 !== 127) begin bad++; $display("FAIL sat_pos got %0d want 127", out2); end
    total++; if (sat2 !== 1'b1) begin bad++; $display("FAIL sat_pos_flag got %b want 1", sat2); end
    drain();
    set_all(96, -3072, 0, 2'b00);
    issue(lat);
    total++; if (out2 !== -128) begin bad++; $display("FAIL sat_neg got %0d want -128", out2); end
    total++; if (sat2 !== 1'b1) begin bad++; $display("FAIL sat_neg_flag got %b want 1", sat2); end
    drain();
    act_v = 2'b01;
    issue(lat);
    total++; if (out2 !== 0) begin bad++; $display("FAIL sat_neg_relu got %0d want 0", out2); end
    total++; if (sat2 !== 1'b1) begin bad++; $display("FAIL sat_neg_relu_flag got %b want 1", sat2); end
    drain();
  endtask

  task automatic test_truncation();
    int lat;
    set_lane0(1, 512, 2'b00);
    issue(lat);
    total++; if (out2 !== 0) begin bad++; $display("FAIL trunc_pos got %0d want 0", out2); end
    drain();
    set_lane0(1, -512, 2'b00);
    issue(lat);
    total++; if (out2 !== -1) begin bad++; $display("FAIL trunc_neg got %0d want -1", out2); end
    drain();
    act_v = 2'b10;
    issue(lat);
    total++; if (out2 !== -1) begin bad++; $display("FAIL trunc_leaky got %0d want -1", out2); end
    drain();
    act_v = 2'b11;
    issue(lat);
    total++; if (out2 !== 0) begin bad++; $display("FAIL trunc_act11 got %0d want 0", out2); end
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    set_all(32, 512, 16, 2'b01);
    issue(lat);
    set_all(96, 3072, 0, 2'b00);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (vld2 !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got %b want 1", c, vld2); end
      total++; if (out2 !== 80) begin bad++; $display("FAIL bp_out[%0d] got %0d want 80", c, out2); end
      total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL bp_sat[%0d] got %b want 0", c, sat2); end
      total++; if (rdy2 !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got %b want 0", c, rdy2); end
    end
    in_valid = 1'b0;
    drain();
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL bp_release_valid got %b want 0", vld2); end
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL bp_release_ready got %b want 1", rdy2); end
    set_all(32, -1024, 0, 2'b10);
    issue(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL b2b_latency got %0d want 3", lat); end
    total++; if (out2 !== -16) begin bad++; $display("FAIL b2b_out got %0d want -16", out2); end
    drain();
  endtask

  task automatic test_abort_latency();
    int l1, l2, l4;
    set_all(96, 3072, 16, 2'b00);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (rdy2 !== 1'b1) begin bad++; $display("FAIL abort_in_ready got %b want 1", rdy2); end
    total++; if (vld2 !== 1'b0) begin bad++; $display("FAIL abort_out_valid got %b want 0", vld2); end
    total++; if (out2 !== 0) begin bad++; $display("FAIL abort_out got %0d want 0", out2); end
    total++; if (sat2 !== 1'b0) begin bad++; $display("FAIL abort_sat got %b want 0", sat2); end
    set_all(32, 512, 16, 2'b01);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    l1 = 0; l2 = 0; l4 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (vld1 && l1 == 0) l1 = c;
      if (vld2 && l2 == 0) l2 = c;
      if (vld4 && l4 == 0) l4 = c;
    end
    total++; if (l1 != 5) begin bad++; $display("FAIL lat_p1 got %0d want 5", l1); end
    total++; if (l2 != 3) begin bad++; $display("FAIL lat_p2 got %0d want 3", l2); end
    total++; if (l4 != 2) begin bad++; $display("FAIL lat_p4 got %0d want 2", l4); end
    total++; if (out1 !== 80) begin bad++; $display("FAIL out_p1 got %0d want 80", out1); end
    total++; if (out2 !== 80) begin bad++; $display("FAIL out_p2 got %0d want 80", out2); end
    total++; if (out4 !== 80) begin bad++; $display("FAIL out_p4 got %0d want 80", out4); end
    total++; if (sat1 !== 1'b0) begin bad++; $display("FAIL sat_p1 got %b want 0", sat1); end
    total++; if (sat4 !== 1'b0) begin bad++; $display("FAIL sat_p4 got %b want 0", sat4); end
    drain();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_all(0, 0, 0, 2'b00);
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_truncation();
    test_back_to_back();
    test_abort_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
